// File: rtl/vga_line_fetch_module_if.sv
// Line-fetch bus: line-load tag, SDRAM burst read port, line-buffer write port.
interface vga_line_fetch_module_if #(
  parameter int ADDR_W = 22
);
  logic [10:0]       tag;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              wr_en;
  logic [9:0]        wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic              overrun;

  // The fetch block itself.
  modport slave (
    input  tag, rd_ack, rd_valid, rd_data,
    output rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done, overrun
  );

  // Display engine plus SDRAM controller side.
  modport master (
    output tag, rd_ack, rd_valid, rd_data,
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done, overrun
  );
endinterface

// File: rtl/vga_line_fetch_module.sv
// Fetches one display line from the SDRAM frame buffer in fixed bursts and
// writes it into the bank of the line buffer selected by the line's LSB.
module vga_line_fetch_module #(
  parameter int                XSIZE     = 320,
  parameter int                YSIZE     = 240,
  parameter int                BURST     = 8,
  parameter int                ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                    clk,
  input logic                    rst_n,
  vga_line_fetch_module_if.slave bus
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic [8:0]        col;
  logic              bank;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              accept;
  logic              last_beat;
  logic              last_col;
  logic              beat_in;

  assign accept    = (state == IDLE) && bus.tag[10] && (bus.tag[9:0] < 10'(YSIZE));
  assign beat_in   = (state == DATA) && bus.rd_valid;
  assign last_beat = (beat == BW'(BURST - 1));
  assign last_col  = (({1'b0, col} + 10'd1) == 10'(XSIZE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one burst outstanding at a time, line ends after XSIZE beats.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (bus.rd_ack) state_nxt = DATA;
      DATA:    if (beat_in && last_beat) state_nxt = last_col ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and busy follow the state directly; busy spans REQ and DATA.
  always_comb begin
    bus.rd_req  = (state == REQ);
    bus.busy    = (state != IDLE);
    bus.rd_addr = rd_addr_q;
  end

  // Datapath: line latch, burst address, beat/column counters, registered write port and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      bank        <= 1'b0;
      col         <= '0;
      beat        <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.wr_en   <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= bus.tag[10] && (state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            bank      <= bus.tag[0];
            col       <= '0;
            rd_addr_q <= BASE_ADDR + ADDR_W'(bus.tag[9:0]) * ADDR_W'(XSIZE);
          end
        end
        REQ: begin
          if (bus.rd_ack) beat <= '0;
        end
        DATA: begin
          if (beat_in) begin
            bus.wr_en   <= 1'b1;
            bus.wr_data <= bus.rd_data;
            bus.wr_addr <= bank ? (10'(XSIZE) + 10'(col)) : 10'(col);
            col         <= col + 9'd1;
            beat        <= beat + BW'(1);
            if (last_beat) begin
              if (last_col) bus.done <= 1'b1;
              else          rd_addr_q <= rd_addr_q + ADDR_W'(BURST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_module.sv
// Scoreboard bench: two instances (BASE_ADDR 0 and 1000) driven by one SDRAM
// controller model; expected requests and writes are queued as stimulus is driven.
module tb_vga_line_fetch_module;

  localparam int          XSIZE  = 320;
  localparam int          YSIZE  = 240;
  localparam int          BURST  = 8;
  localparam int          ADDR_W = 22;
  localparam int          NB     = XSIZE / BURST;
  localparam logic [21:0] BASE1  = 22'd1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] tag = '0;
  logic        rd_ack = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;

  always #5 clk = ~clk;

  vga_line_fetch_module_if #(.ADDR_W(ADDR_W)) b0 ();
  vga_line_fetch_module_if #(.ADDR_W(ADDR_W)) b1 ();

  assign b0.tag = tag;      assign b1.tag = tag;
  assign b0.rd_ack = rd_ack;   assign b1.rd_ack = rd_ack;
  assign b0.rd_valid = rd_valid; assign b1.rd_valid = rd_valid;
  assign b0.rd_data = rd_data;  assign b1.rd_data = rd_data;

  vga_line_fetch_module #(
    .XSIZE(XSIZE), .YSIZE(YSIZE), .BURST(BURST), .ADDR_W(ADDR_W), .BASE_ADDR(22'd0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  vga_line_fetch_module #(
    .XSIZE(XSIZE), .YSIZE(YSIZE), .BURST(BURST), .ADDR_W(ADDR_W), .BASE_ADDR(BASE1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected request addresses and writes {last, addr[9:0], data[15:0]}.
  logic [21:0] rq0[$], rq1[$];
  logic [26:0] wq0[$], wq1[$];
  logic [21:0] held0 = '0, held1 = '0;
  logic [26:0] e0, e1;
  logic        req0_d = 1'b0, req1_d = 1'b0;
  int          wr_cnt0 = 0, wr_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;
  int          ovr_cnt0 = 0, ovr_cnt1 = 0;
  int          model_col = 0;
  logic        model_bank = 1'b0;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      req0_d = 1'b0;
      req1_d = 1'b0;
    end else begin
      if (b0.rd_req && !req0_d) begin
        if (rq0.size() == 0) check_eq("req0_unexpected", 1, 0);
        else begin held0 = rq0.pop_front(); check_eq("req0_addr", b0.rd_addr, held0); end
      end
      if (b0.rd_req && rd_ack) check_eq("req0_addr_hold", b0.rd_addr, held0);
      req0_d = b0.rd_req;
      if (b1.rd_req && !req1_d) begin
        if (rq1.size() == 0) check_eq("req1_unexpected", 1, 0);
        else begin held1 = rq1.pop_front(); check_eq("req1_addr", b1.rd_addr, held1); end
      end
      if (b1.rd_req && rd_ack) check_eq("req1_addr_hold", b1.rd_addr, held1);
      req1_d = b1.rd_req;

      if (b0.wr_en) begin
        wr_cnt0++;
        if (wq0.size() == 0) check_eq("wr0_unexpected", 1, 0);
        else begin
          e0 = wq0.pop_front();
          check_eq("wr0_addr", b0.wr_addr, e0[25:16]);
          check_eq("wr0_data", b0.wr_data, e0[15:0]);
          check_eq("wr0_done", b0.done, e0[26]);
        end
      end else if (b0.done) check_eq("done0_without_write", 1, 0);
      if (b1.wr_en) begin
        wr_cnt1++;
        if (wq1.size() == 0) check_eq("wr1_unexpected", 1, 0);
        else begin
          e1 = wq1.pop_front();
          check_eq("wr1_addr", b1.wr_addr, e1[25:16]);
          check_eq("wr1_data", b1.wr_data, e1[15:0]);
          check_eq("wr1_done", b1.done, e1[26]);
        end
      end else if (b1.done) check_eq("done1_without_write", 1, 0);
      if (b0.done) done_cnt0++;
      if (b1.done) done_cnt1++;
      if (b0.overrun) ovr_cnt0++;
      if (b1.overrun) ovr_cnt1++;
    end
  end

  task automatic send_tag(input logic [9:0] line);
    tag = {1'b1, line};
    @(negedge clk);
    tag = '0;
  endtask

  task automatic push_reqs(input int line, input int nb);
    for (int k = 0; k < nb; k++) begin
      rq0.push_back(22'(line * XSIZE + k * BURST));
      rq1.push_back(BASE1 + 22'(line * XSIZE + k * BURST));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_rd_req"}, b0.rd_req, 0);
    check_eq({name, "_busy"}, b0.busy, 0);
    check_eq({name, "_wr_en"}, b0.wr_en, 0);
    check_eq({name, "_done"}, b0.done, 0);
    check_eq({name, "_overrun"}, b0.overrun, 0);
    check_eq({name, "_rd_addr"}, b0.rd_addr, 0);
    check_eq({name, "_wr_addr"}, b0.wr_addr, 0);
    check_eq({name, "_wr_data"}, b0.wr_data, 0);
    check_eq({name, "_rd_addr1"}, b1.rd_addr, 0);
  endtask

  // Controller model: wait for a request, ack after a random delay, then beats with random gaps.
  task automatic do_burst(input int dmax, input int gmax, input int nbeats);
    int t = 0;
    while (!b0.rd_req && t < 300) begin @(negedge clk); t++; end
    if (!b0.rd_req) begin check_eq("req_timeout", 0, 1); return; end
    repeat ($urandom_range(dmax, 0)) @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(gmax, 0)) @(negedge clk);
      rd_valid = 1'b1;
      rd_data  = 16'($urandom);
      e0 = {model_col == XSIZE - 1, 10'(int'(model_bank) * XSIZE + model_col), rd_data};
      wq0.push_back(e0);
      wq1.push_back(e0);
      model_col++;
      @(negedge clk);
      rd_valid = 1'b0;
    end
  endtask

  task automatic fetch_line(input int line, input int dmax, input int gmax);
    int w0 = wr_cnt0;
    int w1 = wr_cnt1;
    int d0 = done_cnt0;
    int d1 = done_cnt1;
    push_reqs(line, NB);
    model_bank = 1'(line % 2);
    model_col  = 0;
    send_tag(10'(line));
    check_eq("busy_after_tag", b0.busy, 1);
    for (int k = 0; k < NB; k++) do_burst(dmax, gmax, BURST);
    repeat (3) @(negedge clk);
    check_eq("busy_after_line", b0.busy, 0);
    check_eq("busy1_after_line", b1.busy, 0);
    check_eq("write_count0", wr_cnt0 - w0, XSIZE);
    check_eq("write_count1", wr_cnt1 - w1, XSIZE);
    check_eq("done_count0", done_cnt0 - d0, 1);
    check_eq("done_count1", done_cnt1 - d1, 1);
    check_eq("queues_drained", rq0.size() + rq1.size() + wq0.size() + wq1.size(), 0);
  endtask

  initial begin
    int o0, o1, w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fetch_line(0, 0, 0);
    fetch_line(5, 0, 0);
    fetch_line(3, 10, 3);
    fetch_line(4, 10, 3);

    // Second tag 100 cycles into a fetch is dropped with a single overrun pulse.
    o0 = ovr_cnt0;
    o1 = ovr_cnt1;
    fork
      fetch_line(9, 2, 1);
      begin
        repeat (100) @(negedge clk);
        tag = {1'b1, 10'd20};
        @(negedge clk);
        tag = '0;
      end
    join
    repeat (30) @(negedge clk);
    check_eq("overrun_pulses0", ovr_cnt0 - o0, 1);
    check_eq("overrun_pulses1", ovr_cnt1 - o1, 1);

    // Blank-row tags: no fetch, no busy, no overrun.
    send_tag(10'd240);
    for (int i = 0; i < 10; i++) begin
      check_eq("blank_busy", b0.busy, 0);
      check_eq("blank_req", b0.rd_req, 0);
      check_eq("blank_overrun", b0.overrun, 0);
      @(negedge clk);
    end
    send_tag(10'd1023);
    repeat (5) @(negedge clk);
    check_eq("blank_busy_1023", b0.busy, 0);
    check_eq("blank_overrun_total", ovr_cnt0 - o0, 1);

    // Reset during burst 10 after 4 beats, then stray beats after release.
    push_reqs(2, 11);
    model_bank = 1'b0;
    model_col  = 0;
    send_tag(10'd2);
    for (int k = 0; k < 10; k++) do_burst(3, 1, BURST);
    do_burst(3, 1, 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = wr_cnt0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1;
      rd_data  = 16'($urandom);
      @(negedge clk);
      rd_valid = 1'b0;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check_eq("stray_beats_writes", wr_cnt0 - w, 0);
    check_eq("stray_beats_busy", b0.busy, 0);
    check_eq("stray_beats_req", b0.rd_req, 0);
    check_eq("stray_queues", rq0.size() + wq0.size(), 0);

    fetch_line(6, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
